// File: rtl/tx_frame_reader.sv
// -----------------------------------------------------------------------------
// tx_frame_reader
//
// Purpose:
//   Takes a frame descriptor (start address, byte length) from the output
//   queue. Reads the frame out of the shared frame buffer, which is a
//   synchronous RAM with one cycle of read latency. Streams the bytes to the
//   egress MAC over a valid/ready byte interface, marking the last byte.
//   Afterwards it pulses done so the buffer slot can be freed, and it holds
//   off the next descriptor for the inter-frame gap.
//
// Configuration macro:
//   TX_PAD_EN - when defined, frames shorter than MIN_LEN are padded with
//               0x00 bytes up to MIN_LEN. A zero-length descriptor still
//               completes without streaming anything.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   i_desc_valid    descriptor available
//   o_desc_ready    descriptor accepted when valid && ready
//   i_desc_addr     frame start byte address (wraps modulo 2^ADDR_W)
//   i_desc_len      frame length in bytes
//   o_mem_rd_en     frame buffer read strobe
//   o_mem_rd_addr   frame buffer read address
//   i_mem_rd_data   read data, valid the cycle after o_mem_rd_en
//   o_tx_data       egress byte
//   o_tx_valid      egress byte valid
//   o_tx_last       final byte of the frame (qualified by o_tx_valid)
//   i_tx_ready      egress MAC accepts the byte when valid && ready
//   o_done          one-cycle pulse when a frame is finished
//   o_busy          high in every state except IDLE
// -----------------------------------------------------------------------------
module tx_frame_reader #(
    parameter int ADDR_W     = 12,
    parameter int LEN_W      = 11,
    parameter int IFG_CYCLES = 12,
    parameter int MIN_LEN    = 60
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_desc_valid,
    output logic              o_desc_ready,
    input  logic [ADDR_W-1:0] i_desc_addr,
    input  logic [LEN_W-1:0]  i_desc_len,
    output logic              o_mem_rd_en,
    output logic [ADDR_W-1:0] o_mem_rd_addr,
    input  logic [7:0]        i_mem_rd_data,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    output logic              o_tx_last,
    input  logic              i_tx_ready,
    output logic              o_done,
    output logic              o_busy
);

    localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (IFG_CYCLES > 0) ? GAP_W'(IFG_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_GAP,
        S_DONE_ONLY
    } state_t;

    state_t            r_state;
    state_t            w_nextState;

    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_remain;
    logic              r_inflight;
    logic              r_inflightLast;
    logic [7:0]        r_fifoData [2];
    logic              r_fifoLast [2];
    logic              r_wrPtr;
    logic              r_rdPtr;
    logic [1:0]        r_count;
    logic [GAP_W-1:0]  r_gapCnt;
    logic              r_doneFrame;

    logic              w_descFire;
    logic              w_pop;
    logic              w_lastPop;
    logic [2:0]        w_occupancy;
    logic              w_slotFree;
    logic              w_issue;
    logic              w_issueRead;
    logic              w_issueLast;
    logic [LEN_W-1:0]  w_effLen;
    logic [7:0]        w_pushData;

`ifdef TX_PAD_EN
    logic [LEN_W-1:0]  r_readRemain;
    logic              r_inflightPad;

    assign w_effLen    = (i_desc_len < LEN_W'(MIN_LEN)) ? LEN_W'(MIN_LEN) : i_desc_len;
    // Once the real bytes are all requested, the remaining issue slots are
    // pad bytes that travel down the same one-cycle pipe without a RAM read.
    assign w_issueRead = w_issue && (r_readRemain != '0);
    assign w_pushData  = r_inflightPad ? 8'h00 : i_mem_rd_data;
`else
    assign w_effLen    = i_desc_len;
    assign w_issueRead = w_issue;
    assign w_pushData  = i_mem_rd_data;
`endif

    assign w_descFire  = i_desc_valid && o_desc_ready;
    assign w_pop       = o_tx_valid && i_tx_ready;
    assign w_lastPop   = w_pop && o_tx_last;

    // A byte leaving the FIFO this cycle frees its slot immediately, which
    // is what sustains one byte per cycle with only two entries.
    assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_slotFree  = (w_occupancy < 3'd2);
    assign w_issue     = (r_state == S_READ) && w_slotFree;
    assign w_issueLast = w_issue && (r_remain == LEN_W'(1));

    assign o_tx_valid  = (r_count != 2'd0);
    assign o_tx_data   = r_fifoData[r_rdPtr];
    assign o_tx_last   = o_tx_valid && r_fifoLast[r_rdPtr];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_descFire) begin
                    w_nextState = (i_desc_len == '0) ? S_DONE_ONLY : S_READ;
                end
            end
            S_READ: begin
                if (w_issueLast) begin
                    w_nextState = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_lastPop) begin
                    w_nextState = (IFG_CYCLES == 0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                if (r_gapCnt == '0) begin
                    w_nextState = S_IDLE;
                end
            end
            S_DONE_ONLY: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // FSM outputs.
    always_comb begin
        o_desc_ready  = (r_state == S_IDLE);
        o_busy        = (r_state != S_IDLE);
        o_done        = r_doneFrame || (r_state == S_DONE_ONLY);
        o_mem_rd_en   = w_issueRead;
        o_mem_rd_addr = r_addr;
    end

    // Descriptor latch, issue counting, read pipe tracking and gap timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr         <= '0;
            r_remain       <= '0;
            r_inflight     <= 1'b0;
            r_inflightLast <= 1'b0;
            r_doneFrame    <= 1'b0;
            r_gapCnt       <= '0;
        end else begin
            r_inflight     <= w_issue;
            r_inflightLast <= w_issueLast;
            r_doneFrame    <= w_lastPop;
            if (w_descFire) begin
                r_addr   <= i_desc_addr;
                r_remain <= w_effLen;
            end else if (w_issue) begin
                r_remain <= r_remain - LEN_W'(1);
                if (w_issueRead) begin
                    r_addr <= r_addr + ADDR_W'(1);
                end
            end
            if ((r_state == S_DRAIN) && w_lastPop) begin
                r_gapCnt <= GAP_LOAD;
            end else if ((r_state == S_GAP) && (r_gapCnt != '0)) begin
                r_gapCnt <= r_gapCnt - GAP_W'(1);
            end
        end
    end

`ifdef TX_PAD_EN
    // Tracks how many of the remaining issue slots still need a RAM read.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_readRemain  <= '0;
            r_inflightPad <= 1'b0;
        end else begin
            r_inflightPad <= w_issue && !w_issueRead;
            if (w_descFire) begin
                r_readRemain <= i_desc_len;
            end else if (w_issueRead) begin
                r_readRemain <= r_readRemain - LEN_W'(1);
            end
        end
    end
`endif

    // Two-entry byte FIFO; the head entry drives the egress port directly.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr <= 1'b0;
            r_rdPtr <= 1'b0;
            r_count <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_fifoData[i] <= 8'h00;
                r_fifoLast[i] <= 1'b0;
            end
        end else begin
            if (r_inflight) begin
                r_fifoData[r_wrPtr] <= w_pushData;
                r_fifoLast[r_wrPtr] <= r_inflightLast;
                r_wrPtr             <= ~r_wrPtr;
            end
            if (w_pop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

endmodule

// File: doc/tx_frame_reader.md
Name: tx_frame_reader

Overview:
Transmit-side counterpart of the receive commit/trash control. Accepts a frame descriptor (buffer start address and byte length) from the output queue. Reads the frame bytes from the shared frame buffer (synchronous RAM, 1-cycle read latency) and streams them to the egress MAC over a valid/ready byte interface with an end-of-frame marker. Pulses done so the buffer manager can free the slot, then enforces the inter-frame gap before accepting the next descriptor.

Parameters:
ADDR_W, 12, frame buffer byte-address width; addresses wrap modulo 2^ADDR_W
LEN_W, 11, descriptor length width in bytes
IFG_CYCLES, 12, idle cycles after the last byte of a frame is accepted before desc_ready rises; 0 is legal
MIN_LEN, 60, minimum frame length used only when TX_PAD_EN is defined

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
desc_valid  in  1  descriptor available
desc_ready  out  1  descriptor accepted on desc_valid && desc_ready
desc_addr  in  ADDR_W  start byte address of the frame in the buffer
desc_len  in  LEN_W  frame length in bytes
mem_rd_en  out  1  buffer read strobe
mem_rd_addr  out  ADDR_W  buffer read address
mem_rd_data  in  8  read data, valid in the cycle after mem_rd_en
tx_data  out  8  egress byte
tx_valid  out  1  tx_data valid
tx_last  out  1  marks the final byte of the frame; qualified by tx_valid
tx_ready  in  1  egress MAC accepts the byte on tx_valid && tx_ready
done  out  1  one-cycle pulse when a frame is finished
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state IDLE, FIFO flushed, counters cleared. desc_ready=1; mem_rd_en=0, mem_rd_addr=0, tx_valid=0, tx_last=0, tx_data=0, done=0, busy=0.
- Reset mid-frame aborts the frame immediately: no done pulse, no further tx_valid.
- States:
  - IDLE: desc_ready=1. On handshake, latch addr and len. If len=0, go to DONE_ONLY; otherwise go to READ.
  - READ: issue reads at consecutive addresses, incrementing modulo 2^ADDR_W. Go to DRAIN when the last read has been issued.
  - DRAIN: wait until the last byte has been accepted.
  - GAP: count IFG_CYCLES, then go to IDLE.
  - DONE_ONLY: pulse done, then go to IDLE.
- Internal 2-entry byte FIFO. Read data is written into it in the cycle after mem_rd_en.
  - mem_rd_en is asserted only when (FIFO occupancy + reads in flight) < 2. Overflow is impossible.
  - tx_data and tx_valid are driven from the FIFO head (registered storage); tx_valid = FIFO not empty.
- Latency: with tx_ready=1, the first mem_rd_en is in the cycle after descriptor acceptance (cycle 1). The first tx_valid is in cycle 3. Throughput is then one byte per cycle.
- Stream rule: once tx_valid=1, tx_data and tx_last stay stable until tx_ready. tx_ready may toggle arbitrarily.
- tx_last is asserted with the byte whose index equals the effective length minus 1.
- On the final byte handshake: done=1 in the next cycle and the state enters GAP.
  - desc_ready=0 for IFG_CYCLES cycles after that handshake cycle, then returns to 1.
  - If IFG_CYCLES=0, the state goes straight to IDLE; desc_ready=1 in the cycle after the handshake.
- desc_len=0: the descriptor is consumed, there are no reads and no tx_valid, done pulses in the next cycle, and there is no gap.
- Descriptors presented while desc_ready=0 are ignored; the upstream holds desc_valid.
- done and the tx handshake can never coincide for different frames.

Optional Feature:
TX_PAD_EN
- Defined: effective length = max(desc_len, MIN_LEN) for desc_len≥1. Bytes past desc_len are 0x00, are inserted directly into the FIFO without memory reads, and obey the same occupancy rule. tx_last is on byte MIN_LEN-1 for short frames. desc_len=0 still follows the DONE_ONLY path.
- Undefined: effective length = desc_len; no padding logic is present.

Test Plan:
- Frame with desc_addr=0x010, len=4, tx_ready=1, IFG=12, memory holding AA BB CC DD -> mem_rd_en in cycles 1-4 at addresses 0x010-0x013; tx bytes AA BB CC DD in cycles 3-6; tx_last in cycle 6; done in cycle 7; desc_ready low cycles 7-18, high in cycle 19.
- Same frame with tx_ready=0 for cycles 3-8 -> tx_valid held with AA stable; no more than 2 reads outstanding plus buffered; all 4 bytes delivered in order, no duplicates.
- desc_addr=0xFFE, len=4 -> read addresses 0xFFE, 0xFFF, 0x000, 0x001; tx_last on the 4th byte.
- desc_len=0 -> no mem_rd_en, no tx_valid; done in cycle 1; desc_ready=1 in cycle 2.
- Two back-to-back descriptors with IFG_CYCLES=0 -> second descriptor accepted in the cycle after the first frame's tx_last handshake; streams are contiguous apart from the 3-cycle startup.
- Reset asserted while the 3rd byte of a 10-byte frame is pending -> in the next cycle tx_valid=0, busy=0, desc_ready=1; no done pulse. With TX_PAD_EN, len=10 -> 60 bytes, bytes 10-59 are 0x00, tx_last on byte 59, exactly 10 reads.
